fifo_access_scheduler: RTL and testbench

//  Sequences the 16-entry byte FIFO between the crypto/CRC host path, the UART RX path and the UART TX.

---
 rtl/fifo_sched_pkg.sv | 19 +
 rtl/rr_arb2.sv | 43 ++++
 rtl/fifo_access_scheduler.sv | 113 +++++++++++
 tb/tb_fifo_access_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sched_pkg : shared constants and read-FSM encoding for the  |
// | FIFO access scheduler.                 Rev 1.0 - initial release |
// +------------------------------------------------------------------+
package fifo_sched_pkg;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_RD      = 3'd1,
        RD_START   = 3'd2,
        RD_WAIT_HI = 3'd3,
        RD_WAIT_LO = 3'd4
    } rd_state_t;
endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb2 : two-requester arbiter, req[0]=host, req[1]=RX.         |
// | FIFO_SCHED_RX_PRIO_EN selects strict RX priority (no pointer).   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
`ifdef FIFO_SCHED_RX_PRIO_EN
    logic w_unused;
    assign w_unused = ^{clk, rst, advance};

    always_comb begin
        gnt = 2'b00;
        if (req[1])      gnt = 2'b10;
        else if (req[0]) gnt = 2'b01;
    end
`else
    // r_ptr names the requester favoured on a tie: 0 = host, 1 = RX
    logic r_ptr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)          r_ptr <= 1'b0;
        else if (advance) r_ptr <= gnt[0];
    end
`endif
endmodule
`default_nettype wire

// File: rtl/fifo_access_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_access_scheduler : arbitrates host/RX bytes into the FIFO,  |
// | shadows occupancy and paces reads to baud tick and TX busy.      |
// | Option macro: FIFO_SCHED_RX_PRIO_EN (strict RX priority).        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fifo_access_scheduler
    import fifo_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              sched_en,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              baud_tick,
    input  logic              tx_busy,
    output logic              fifo_rd_en,
    output logic              tx_start,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic              w_room;
    logic              w_rd_go;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;

    assign full  = (r_count == CNT_W'(DEPTH - 1));
    assign empty = (r_count == '0);
    assign count = r_count;

    // Count the write still in the strobe register so back-to-back grants cannot overfill
    assign w_room = (r_count + CNT_W'(r_wr_en)) < CNT_W'(DEPTH - 1);
    assign w_req  = {rx_valid, host_valid} & {2{sched_en & w_room}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (reset),
        .req     (w_req),
        .advance (|w_gnt),
        .gnt     (w_gnt)
    );

    assign host_ready   = w_gnt[0];
    assign rx_ready     = w_gnt[1];
    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= |w_gnt;
            if (w_gnt[1])      r_wr_data <= rx_data;
            else if (w_gnt[0]) r_wr_data <= host_data;
        end
    end

    assign w_rd_go = sched_en & ~empty & baud_tick & ~tx_busy;

    always_ff @(posedge clk) begin
        if (reset) r_state <= RD_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RD_IDLE:    if (w_rd_go) w_state_nxt = RD_RD;
            RD_RD:      w_state_nxt = RD_START;
            RD_START:   w_state_nxt = RD_WAIT_HI;
            RD_WAIT_HI: if (tx_busy)  w_state_nxt = RD_WAIT_LO;
            RD_WAIT_LO: if (!tx_busy) w_state_nxt = RD_IDLE;
            default:    w_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        tx_start   = 1'b0;
        case (r_state)
            RD_IDLE:  fifo_rd_en = w_rd_go;
            RD_START: tx_start   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({r_wr_en, fifo_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_access_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fifo_access_scheduler : directed self-checking bench.         |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_fifo_access_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sched_en = 1'b0;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_ready;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       baud_tick = 1'b0;
    logic       tx_busy = 1'b0;
    logic       fifo_rd_en;
    logic       tx_start;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_access_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .sched_en     (sched_en),
        .host_valid   (host_valid),
        .host_data    (host_data),
        .host_ready   (host_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .baud_tick    (baud_tick),
        .tx_busy      (tx_busy),
        .fifo_rd_en   (fifo_rd_en),
        .tx_start     (tx_start),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; host_valid = 1'b0; rx_valid = 1'b0;
        baud_tick = 1'b0; tx_busy = 1'b0; sched_en = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_host;
        logic [7:0] exp_d [4];
        int hcnt;
        int rcnt;
        int acc;

`ifdef FIFO_SCHED_RX_PRIO_EN
        exp_host = 4'b0000;
        exp_d[0] = 8'h22; exp_d[1] = 8'h23; exp_d[2] = 8'h24; exp_d[3] = 8'h25;
`else
        exp_host = 4'b0101;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h12; exp_d[3] = 8'h23;
`endif

        // Test 1: reset values, single host byte, sched_en gating
        do_reset();
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_tx_start", tx_start, 0);
        sched_en = 1'b0; host_valid = 1'b1; host_data = 8'hA5;
        #1;
        chk("t1_disabled_ready", host_ready, 0);
        sched_en = 1'b1;
        #1;
        chk("t1_host_ready", host_ready, 1);
        chk("t1_rx_ready", rx_ready, 0);
        cyc();
        host_valid = 1'b0;
        #1;
        chk("t1_wr_en", fifo_wr_en, 1);
        chk("t1_wr_data", fifo_wr_data, 8'hA5);
        cyc();
        chk("t1_count", count, 1);
        chk("t1_empty", empty, 0);
        chk("t1_wr_en_off", fifo_wr_en, 0);

        // Test 2: both producers contend for four cycles
        do_reset();
        hcnt = 0; rcnt = 0;
        host_valid = 1'b1; rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_data = 8'h11 + 8'(hcnt);
            rx_data   = 8'h22 + 8'(rcnt);
            #1;
            chk("t2_host_ready", host_ready, exp_host[i]);
            chk("t2_rx_ready", rx_ready, !exp_host[i]);
            if (host_ready) hcnt++;
            if (rx_ready) rcnt++;
            cyc();
            chk("t2_wr_data", fifo_wr_data, exp_d[i]);
            chk("t2_count_lag", count, i);
        end
        host_valid = 1'b0; rx_valid = 1'b0;
        cyc();
        chk("t2_count", count, 4);

        // Test 3: fill to capacity, one read frees a slot
        do_reset();
        acc = 0;
        host_valid = 1'b1; host_data = 8'h3C;
        for (int k = 0; k < 60 && acc < 15; k++) begin
            #1;
            if (host_ready) acc++;
            cyc();
        end
        cyc(); cyc();
        #1;
        chk("t3_accepted", acc, 15);
        chk("t3_count_full", count, 15);
        chk("t3_full", full, 1);
        chk("t3_ready_blocked", host_ready, 0);
        baud_tick = 1'b1;
        #1;
        chk("t3_rd_en", fifo_rd_en, 1);
        cyc();
        baud_tick = 1'b0;
        #1;
        chk("t3_count_14", count, 14);
        chk("t3_full_off", full, 0);
        chk("t3_ready_again", host_ready, 1);
        cyc();
        host_valid = 1'b0;
        cyc();
        chk("t3_refull", count, 15);
        chk("t3_refull_flag", full, 1);

        // Test 4: read pacing against baud tick and tx_busy
        do_reset();
        host_valid = 1'b1; host_data = 8'h5A;
        cyc(); cyc();
        host_valid = 1'b0;
        cyc();
        chk("t4_count2", count, 2);
        baud_tick = 1'b1;
        #1;
        chk("t4_rd_en", fifo_rd_en, 1);
        cyc();
        baud_tick = 1'b0;
        #1;
        chk("t4_rd_en_off", fifo_rd_en, 0);
        chk("t4_tx_start_early", tx_start, 0);
        chk("t4_count1", count, 1);
        cyc();
        chk("t4_tx_start", tx_start, 1);
        tx_busy = 1'b1;
        cyc();
        chk("t4_tx_start_off", tx_start, 0);
        for (int j = 0; j < 9; j++) begin
            baud_tick = 1'b1;
            #1;
            chk("t4_no_read_busy", fifo_rd_en, 0);
            cyc();
        end
        tx_busy = 1'b0; baud_tick = 1'b0;
        cyc();
        #1;
        chk("t4_no_read_no_tick", fifo_rd_en, 0);
        baud_tick = 1'b1;
        #1;
        chk("t4_second_rd", fifo_rd_en, 1);
        cyc();
        baud_tick = 1'b0;
        chk("t4_count0", count, 0);
        chk("t4_empty", empty, 1);

        // Test 5: write and read strobes in the same cycle
        do_reset();
        host_valid = 1'b1; host_data = 8'h77;
        for (int j = 0; j < 5; j++) cyc();
        host_valid = 1'b0;
        cyc();
        chk("t5_count5", count, 5);
        host_valid = 1'b1;
        cyc();
        host_valid = 1'b0; baud_tick = 1'b1;
        #1;
        chk("t5_wr_en", fifo_wr_en, 1);
        chk("t5_rd_en", fifo_rd_en, 1);
        cyc();
        baud_tick = 1'b0;
        chk("t5_count_same", count, 5);

        // Test 6: reset while waiting for TX to finish
        do_reset();
        host_valid = 1'b1; host_data = 8'h99;
        for (int j = 0; j < 4; j++) cyc();
        host_valid = 1'b0;
        cyc();
        baud_tick = 1'b1;
        #1;
        chk("t6_rd_en", fifo_rd_en, 1);
        cyc();
        baud_tick = 1'b0;
        cyc();
        chk("t6_tx_start", tx_start, 1);
        tx_busy = 1'b1;
        cyc(); cyc();
        chk("t6_count3", count, 3);
        host_valid = 1'b1;
        #1;
        chk("t6_ready", host_ready, 1);
        cyc();
        host_valid = 1'b0;
        chk("t6_pending_wr", fifo_wr_en, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("t6_count0", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_wr_en", fifo_wr_en, 0);
        chk("t6_rd_en_off", fifo_rd_en, 0);
        chk("t6_tx_start_off", tx_start, 0);
        host_valid = 1'b1;
        cyc();
        host_valid = 1'b0;
        cyc();
        chk("t6_count1", count, 1);
        tx_busy = 1'b0; baud_tick = 1'b1;
        #1;
        chk("t6_idle_read", fifo_rd_en, 1);
        cyc();
        baud_tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
